// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC/IR front end with req/ack instruction fetch and one-hot MIPS decode.
// Define FD_ILLEGAL_TRAP_EN to halt on an illegal instruction instead of letting it commit.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ack_i,
  input  logic [31:0] pc_next_i,
  input  logic        commit_i,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic [31:0] instr_index_o,
  output logic        id_valid_o,
  output logic        illegal_o,
  output logic        fetch_err_o
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
`ifdef FD_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [4:0]    idx;
  logic          bad;
  // Index 31 is the catch-all for anything outside the supported set.
  always_comb begin
    idx = 5'd31;
    if (ir_q[31:26] == 6'h00) begin
      case (ir_q[5:0])
        6'h20: idx = 5'd0;
        6'h21: idx = 5'd1;
        6'h22: idx = 5'd2;
        6'h23: idx = 5'd3;
        6'h24: idx = 5'd4;
        6'h25: idx = 5'd5;
        6'h26: idx = 5'd6;
        6'h27: idx = 5'd7;
        6'h2A: idx = 5'd8;
        6'h2B: idx = 5'd9;
        6'h00: idx = 5'd10;
        6'h02: idx = 5'd11;
        6'h03: idx = 5'd12;
        6'h04: idx = 5'd13;
        6'h06: idx = 5'd14;
        6'h07: idx = 5'd15;
        6'h08: idx = 5'd16;
        default: idx = 5'd31;
      endcase
    end else begin
      case (ir_q[31:26])
        6'h08: idx = 5'd17;
        6'h09: idx = 5'd18;
        6'h0C: idx = 5'd19;
        6'h0D: idx = 5'd20;
        6'h0E: idx = 5'd21;
        6'h23: idx = 5'd22;
        6'h2B: idx = 5'd23;
        6'h04: idx = 5'd24;
        6'h05: idx = 5'd25;
        6'h0A: idx = 5'd26;
        6'h0B: idx = 5'd27;
        6'h0F: idx = 5'd28;
        6'h02: idx = 5'd29;
        6'h03: idx = 5'd30;
        default: idx = 5'd31;
      endcase
    end
  end
  assign bad           = idx == 5'd31;
  assign id_valid_o    = state_q == VALID;
  assign imem_req_o    = state_q == FETCH;
  assign imem_addr_o   = pc_q;
  assign instr_index_o = id_valid_o ? 32'd1 << idx : 32'd0;
  assign illegal_o     = id_valid_o & bad;
  assign pc_o          = pc_q;
  assign ir_o          = ir_q;
  assign fetch_err_o   = err_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          cnt_d   = '0;
          state_d = VALID;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      VALID: begin
        if (TRAP && bad) begin
          state_d = HALT;
        end else if (commit_i) begin
          pc_d    = pc_next_i;
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: decode vector table, directed fetch/commit/timeout/reset sequences,
// and a randomized run checked cycle by cycle against a behavioural model.
module tb_fetch_decode_stage;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int TMO = 16;
`ifdef FD_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [5:0] FN [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                       6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] OP [0:13] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                                       6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};
  logic clk = 0, rst_n = 0, ack = 0, commit = 0;
  logic [31:0] rdata = 0, pc_next = 0;
  logic req, id_valid, illegal, ferr;
  logic [31:0] addr, pc, ir, idx;
  int n_chk = 0, n_pass = 0;
  int m_ph, m_cnt;
  logic [31:0] m_pc, m_ir;
  bit m_err;
  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .imem_ack_i(ack), .pc_next_i(pc_next), .commit_i(commit), .pc_o(pc), .ir_o(ir),
    .instr_index_o(idx), .id_valid_o(id_valid), .illegal_o(illegal), .fetch_err_o(ferr));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] word;
    logic [31:0] want_idx;
    logic        want_ill;
  } vec_t;
  vec_t vt [15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask
  function automatic int dec(input logic [31:0] w);
    for (int i = 0; i < 17; i++) if (w[31:26] == 6'h00 && w[5:0] == FN[i]) return i;
    for (int i = 0; i < 14; i++) if (w[31:26] == OP[i]) return 17 + i;
    return 31;
  endfunction
  // Phases: 0 idle, 1 fetching, 2 instruction held for the controller, 3 halted.
  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_pc = RPC; m_ir = 0; m_err = 0;
  endtask
  task automatic model_step();
    if (m_ph == 0) begin
      m_ph = 1; m_cnt = 0;
    end else if (m_ph == 1) begin
      if (ack) begin m_ir = rdata; m_ph = 2; m_cnt = 0; end
      else if (m_cnt == TMO - 1) begin m_err = 1; m_ph = 3; end
      else m_cnt++;
    end else if (m_ph == 2) begin
      if (TRAP && dec(m_ir) == 31) m_ph = 3;
      else if (commit) begin m_pc = pc_next; m_ph = 1; end
    end
  endtask
  task automatic cmp_model();
    logic v;
    v = m_ph == 2;
    chk("rnd_req", 32'(req), 32'(m_ph == 1));
    chk("rnd_addr", addr, m_pc);
    chk("rnd_pc", pc, m_pc);
    chk("rnd_ir", ir, m_ir);
    chk("rnd_valid", 32'(id_valid), 32'(v));
    chk("rnd_index", idx, v ? 32'd1 << dec(m_ir) : 32'd0);
    chk("rnd_illegal", 32'(illegal), 32'(v && dec(m_ir) == 31));
    chk("rnd_err", 32'(ferr), 32'(m_err));
  endtask
  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 0; ack = 0; commit = 0;
    #1; model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  initial begin
    vt[0]  = '{32'h0000_0022, 32'h0000_0004, 1'b0};
    vt[1]  = '{32'h0000_0027, 32'h0000_0080, 1'b0};
    vt[2]  = '{32'h0000_002B, 32'h0000_0200, 1'b0};
    vt[3]  = '{32'h0000_0003, 32'h0000_1000, 1'b0};
    vt[4]  = '{32'h0000_0008, 32'h0001_0000, 1'b0};
    vt[5]  = '{32'h2000_0000, 32'h0002_0000, 1'b0};
    vt[6]  = '{32'h3800_0000, 32'h0020_0000, 1'b0};
    vt[7]  = '{32'hAC00_0000, 32'h0080_0000, 1'b0};
    vt[8]  = '{32'h1400_0000, 32'h0200_0000, 1'b0};
    vt[9]  = '{32'h3C00_0000, 32'h1000_0000, 1'b0};
    vt[10] = '{32'h0C00_0000, 32'h4000_0000, 1'b0};
    vt[11] = '{32'h0000_0000, 32'h0000_0400, 1'b0};
    vt[12] = '{32'h00A4_3007, 32'h0000_8000, 1'b0};
    vt[13] = '{32'h0000_0001, 32'h8000_0000, 1'b1};
    vt[14] = '{32'h0400_0000, 32'h8000_0000, 1'b1};
    do_reset();
    chk("rst_pc", pc, RPC);
    chk("rst_ir", ir, 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_err", 32'(ferr), 0);
    chk("rst_index", idx, 0);
    // zero-wait add fetch
    tick();
    chk("add_req", 32'(req), 1);
    chk("add_addr", addr, RPC);
    ack = 1; rdata = 32'h0000_0020;
    tick(); ack = 0;
    chk("add_valid", 32'(id_valid), 1);
    chk("add_index", idx, 32'h0000_0001);
    chk("add_req_low", 32'(req), 0);
    // lw with three wait cycles
    commit = 1; pc_next = 32'h0040_0004;
    tick(); commit = 0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_req", 32'(req), 1);
      chk("lw_addr", addr, 32'h0040_0004);
      if (i == 3) begin ack = 1; rdata = 32'h8C08_0000; end
      tick(); ack = 0;
    end
    chk("lw_req_done", 32'(req), 0);
    chk("lw_index", idx, 32'h0040_0000);
    // hold without commit; stray ack must not disturb IR
    for (int i = 0; i < 10; i++) begin
      ack = (i == 3); rdata = 32'h0C00_0000;
      tick(); ack = 0;
      chk("hold_ir", ir, 32'h8C08_0000);
      chk("hold_pc", pc, 32'h0040_0004);
      chk("hold_index", idx, 32'h0040_0000);
    end
    commit = 1; pc_next = 32'hFFFF_FFFC;
    tick(); commit = 0;
    chk("top_addr", addr, 32'hFFFF_FFFC);
    ack = 1; rdata = 32'h0000_0000;
    tick(); ack = 0;
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("nop_index", idx, 32'h0000_0400);
    commit = 1; pc_next = m_pc + 32'd4;
    tick(); commit = 0;
    chk("wrap_addr", addr, 32'h0000_0000);
    // ack timeout from the first FETCH cycle
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_err_early", 32'(ferr), 0);
      tick();
    end
    chk("tmo_err", 32'(ferr), 1);
    chk("tmo_req", 32'(req), 0);
    for (int i = 0; i < 4; i++) begin
      ack = 1; commit = 1; rdata = 32'h0000_0020;
      tick(); ack = 0; commit = 0;
    end
    chk("halt_err", 32'(ferr), 1);
    chk("halt_valid", 32'(id_valid), 0);
    chk("halt_req", 32'(req), 0);
    chk("halt_pc", pc, 32'h0000_0000);
    do_reset();
    chk("clr_err", 32'(ferr), 0);
    tick();
    chk("refetch_addr", addr, RPC);
    chk("refetch_req", 32'(req), 1);
    // illegal opcode
    ack = 1; rdata = 32'hFC00_0000;
    tick(); ack = 0;
    chk("ill_index", idx, 32'h8000_0000);
    chk("ill_flag", 32'(illegal), 1);
    commit = 1; pc_next = 32'h0000_1000;
    tick(); commit = 0;
    if (TRAP) begin
      chk("trap_valid", 32'(id_valid), 0);
      chk("trap_req", 32'(req), 0);
      chk("trap_pc", pc, RPC);
    end else begin
      chk("ill_req", 32'(req), 1);
      chk("ill_addr", addr, 32'h0000_1000);
    end
    // reset in the middle of a fetch; late ack ignored
    do_reset();
    tick();
    chk("mid_req_before", 32'(req), 1);
    rst_n = 0;
    #1;
    chk("mid_req_async", 32'(req), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    ack = 1; rdata = 32'h0000_0020;
    tick(); ack = 0;
    chk("late_ack_ir", ir, 32'h0000_0000);
    chk("late_ack_req", 32'(req), 1);
    chk("late_ack_addr", addr, RPC);
    // decode vector table
    foreach (vt[k]) begin
      do_reset();
      tick();
      ack = 1; rdata = vt[k].word;
      tick(); ack = 0;
      chk("tbl_valid", 32'(id_valid), 1);
      chk("tbl_index", idx, vt[k].want_idx);
      chk("tbl_illegal", 32'(illegal), 32'(vt[k].want_ill));
    end
    // randomized run against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int k;
      if (m_ph == 3) do_reset();
      ack = $urandom_range(0, 9) < 7;
      commit = $urandom_range(0, 1) == 1;
      pc_next = $urandom;
      k = $urandom_range(0, 35);
      if (k < 17) rdata = {6'h00, 20'($urandom), FN[k]};
      else if (k < 31) rdata = {OP[k - 17], 26'($urandom)};
      else rdata = $urandom;
      tick();
      cmp_model();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Fetch and decode front end of the 31-instruction single-cycle-style MIPS core. Sits directly upstream of the controller.
- Holds the PC and fetches from instruction memory over a req/ack handshake. Latches the fetched word into IR and decodes it into the 32-bit one-hot instr_index the controller consumes.
- Advances only when the execute side commits the current instruction. This lets a multi-cycle instruction memory coexist with the combinational controller.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, cycles to wait for imem_ack before flagging fetch_err (must be at least 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  fetch address; equals pc while imem_req is high.
- imem_rdata  in  32  instruction word, valid when imem_ack is high.
- imem_ack  in  1  single-cycle acknowledge.
- pc_next  in  32  next PC from next-PC logic (jump/branch/jr already resolved).
- commit  in  1  execute side finished the current instruction; load pc_next.
- pc  out  32  PC of the instruction in IR.
- ir  out  32  latched instruction.
- instr_index  out  32  one-hot decode of ir.
- id_valid  out  1  ir and instr_index are valid for the controller.
- illegal  out  1  ir is not one of the 31 supported instructions.
- fetch_err  out  1  sticky; ack timeout occurred.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, ir=0, id_valid=0, imem_req=0, illegal=0, fetch_err=0, timeout counter=0, state=IDLE. instr_index=0 because id_valid=0 gates it.
- States:
  - IDLE: imem_req=0. Moves to FETCH on the next cycle, unconditionally.
  - FETCH: imem_req=1, imem_addr=pc, counter increments each cycle.
    - On imem_ack: ir<=imem_rdata, counter<=0, go to VALID.
    - If counter reaches ACK_TIMEOUT-1 without ack: fetch_err<=1, go to HALT.
  - VALID: id_valid=1, imem_req=0.
    - On commit: pc<=pc_next, id_valid falls next cycle, go to FETCH.
    - Without commit: hold indefinitely. ir and pc are stable.
  - HALT: all outputs frozen, imem_req=0, id_valid=0. Only reset exits.
- Latency: one ack cycle to id_valid high on the next clock. Commit to the next imem_req is 1 cycle. Minimum 2 cycles per instruction.
- commit outside VALID is ignored. imem_ack outside FETCH is ignored and does not update ir.
- ack and timeout in the same cycle: ack wins.
- instr_index is combinational from ir and is forced to 0 when id_valid=0. Exactly one bit is set when valid.
- R-type (opcode 0), decoded by funct:
  - 20→0 add, 21→1 addu, 22→2 sub, 23→3 subu, 24→4 and, 25→5 or, 26→6 xor, 27→7 nor
  - 2A→8 slt, 2B→9 sltu, 00→10 sll, 02→11 srl, 03→12 sra
  - 04→13 sllv, 06→14 srlv, 07→15 srav, 08→16 jr
- Other opcodes:
  - 08→17 addi, 09→18 addiu, 0C→19 andi, 0D→20 ori, 0E→21 xori
  - 23→22 lw, 2B→23 sw, 04→24 beq, 05→25 bne
  - 0A→26 slti, 0B→27 sltiu, 0F→28 lui, 02→29 j, 03→30 jal
- Anything else: bit 31 set, illegal=1. ir=0 (sll $0,$0,0) decodes as bit 10, a legal NOP.
- pc wraps modulo 2^32. Misalignment is not checked; imem_addr is pc verbatim.
- Reset asserted mid-FETCH drops imem_req asynchronously. A late ack after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: FD_ILLEGAL_TRAP_EN.
- Defined: an illegal decode in VALID holds for that cycle with id_valid=1 and illegal=1. The next cycle goes to HALT regardless of commit, and pc is not updated.
- Undefined: an illegal instruction behaves like any other; commit advances normally. The controller sees bit 31, which asserts no write enables.

Test Plan:
- Reset, then a zero-wait ack returning 0x0000_0020 (add): imem_addr=0x0040_0000; next cycle id_valid=1 and instr_index=0x0000_0001.
- Commit with pc_next=0x0040_0004, ack after 3 wait cycles with 0x8C08_0000 (lw): imem_req high for 4 cycles at 0x0040_0004; instr_index=0x0040_0000.
- Hold VALID 10 cycles without commit, with a stray ack and rdata=0x0C00_0000: ir, pc and instr_index unchanged; then commit with pc_next=0xFFFF_FFFC and check pc wraps correctly on the next fetch.
- No ack for ACK_TIMEOUT=16 cycles: fetch_err=1 on cycle 16 and the block stays in HALT; rst_n pulse clears fetch_err and refetches RESET_PC.
- Fetch 0xFC00_0000: instr_index=0x8000_0000, illegal=1. With FD_ILLEGAL_TRAP_EN, commit is ignored and the block halts; without it, commit advances pc.
- Assert rst_n low mid-FETCH, ack 1 cycle after release: imem_req=0 immediately, ir stays 0, fetch restarts from RESET_PC.
